// File: rtl/regfile_sb_if.sv
// ---------------------------------------------------------------------------
// regfile_sb_if
//   Bundle of the register-file/scoreboard signals shared between the decode
//   logic (fetch read addresses, writeback write port, issue strobe) and the
//   regfile_sb block.
//
//   Parameters
//     XLEN  register data width in bits
//     NREG  number of architectural registers (power of two, >= 2)
//     NRD   number of read ports (1..4)
//
//   Signals (direction as seen from the regfile, i.e. the slave modport)
//     rd_addr               in   NRD*AW    read addresses, port k at [k*AW +: AW]
//     rd_data               out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
//     rd_busy               out  NRD       scoreboard bit of each read address
//     wr_en/wr_addr/wr_data in             writeback write port
//     iss_en/iss_addr       in             issue strobe, marks destination busy
//     busy_vec              out  NREG      full scoreboard
//     busy_cnt              out  AW+1      number of busy registers
//     regfile_for_simulator out  NREG*XLEN flattened register dump
//
//   modport master : the decode/issue/writeback side
//   modport slave  : the register file itself
// ---------------------------------------------------------------------------
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [XLEN-1:0]      wr_data;
  logic                 iss_en;
  logic [AW-1:0]        iss_addr;
  logic [NREG-1:0]      busy_vec;
  logic [AW:0]          busy_cnt;
  logic [NREG*XLEN-1:0] regfile_for_simulator;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, busy_vec, busy_cnt, regfile_for_simulator
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, busy_vec, busy_cnt, regfile_for_simulator
  );
endinterface

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//   Parametrised decode-stage register file with a per-register scoreboard.
//   Writeback writes through the wr_* port, issue logic marks destination
//   registers busy through iss_*, and each of the NRD read ports returns the
//   register value plus its busy bit so the core can detect RAW hazards.
//
//   Optional feature (compile-time macro REGFILE_BYPASS_EN):
//     defined   - a write in the current cycle is forwarded combinationally to
//                 any read port addressing the same register, and that port's
//                 busy bit reads 0 unless the same register is also being
//                 issued this cycle.
//     undefined - reads see only registered state; a write becomes visible on
//                 the edge after it is presented.
//
//   Ports
//     clk  in   rising-edge clock
//     rst  in   asynchronous, active-high reset; clears registers, scoreboard
//               and busy count immediately and blocks writes/issues while high
//     bus  regfile_sb_if.slave (see interface header for the signal list)
//
//   Parameters
//     XLEN, NREG, NRD must match those of the connected interface.
//     ZERO_REG = 1 makes register 0 read as 0, ignore writes, never be busy.
// ---------------------------------------------------------------------------
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam int AW = $clog2(NREG);
  localparam int CW = AW + 1;

  logic [XLEN-1:0]      regs [NREG];
  logic [NREG-1:0]      busy_q;
  logic [NREG-1:0]      busy_d;
  logic [CW-1:0]        cnt_q;
  logic                 wr_ok;
  logic                 iss_ok;
  logic [NRD*XLEN-1:0]  rd_data_c;
  logic [NRD-1:0]       rd_busy_c;
  logic [NREG*XLEN-1:0] dump_c;

  // Number of set bits; CW bits hold up to NREG, so it cannot wrap.
  function automatic logic [CW-1:0] popcount(input logic [NREG-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < NREG; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Qualified strobes: nothing is written or issued while in reset, and the
  // hard-wired zero register never accepts a write or becomes busy.
  assign wr_ok  = bus.wr_en  && !rst && !is_zero_reg(bus.wr_addr);
  assign iss_ok = bus.iss_en && !rst && !is_zero_reg(bus.iss_addr);

  // Scoreboard next state. The issue set is applied after the writeback
  // clear so that a register issued and written back in the same cycle stays
  // busy: the new producer is still in flight.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[bus.wr_addr] = 1'b0;
    end
    if (iss_ok) begin
      busy_d[bus.iss_addr] = 1'b1;
    end
  end

  // ---- state register: scoreboard and its registered population count ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= popcount(busy_d);
    end
  end

  // ---- state register: architectural register array ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read ports: all identical, each decoding its own address slice.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            b;

    assign a = bus.rd_addr[k*AW +: AW];

    always_comb begin
      d = regs[a];
      b = busy_q[a];
`ifdef REGFILE_BYPASS_EN
      // Forward the in-flight writeback; the register is only still busy if
      // a new producer is issued to it in the same cycle.
      if (wr_ok && (bus.wr_addr == a)) begin
        d = bus.wr_data;
        b = iss_ok && (bus.iss_addr == a);
      end
`endif
      if (is_zero_reg(a)) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign rd_data_c[k*XLEN +: XLEN] = d;
    assign rd_busy_c[k]              = b;
  end

  for (genvar i = 0; i < NREG; i++) begin : g_dump
    assign dump_c[i*XLEN +: XLEN] = regs[i];
  end

  assign bus.rd_data               = rd_data_c;
  assign bus.rd_busy               = rd_busy_c;
  assign bus.busy_vec              = busy_q;
  assign bus.busy_cnt              = cnt_q;
  assign bus.regfile_for_simulator = dump_c;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised register file with a per-register scoreboard.
- Next-generation replacement for the fixed 32x32, 2-read-port decode-stage register file.
- Generalised in data width, register count and read-port count.
- Adds optional write-to-read bypass and busy tracking for in-flight destination registers, so a multi-cycle or pipelined core can detect RAW hazards.
- Sits in decode: fetch supplies the read addresses, writeback supplies the write port, and issue logic marks destinations busy.

Parameters:
- XLEN, 32, register data width in bits.
- NREG, 32, number of architectural registers; power of two, at least 2.
- NRD, 2, number of independent read ports, 1..4.
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never busy.
- Localparam AW = $clog2(NREG), register address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- rd_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
- rd_busy  out  NRD  scoreboard busy bit of each read address.
- wr_en  in  1  writeback write enable.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback data.
- iss_en  in  1  issue strobe: mark iss_addr busy.
- iss_addr  in  AW  destination register of the issuing instruction.
- busy_vec  out  NREG  full scoreboard, bit i = register i busy.
- busy_cnt  out  AW+1  number of busy registers.
- regfile_for_simulator  out  NREG*XLEN  flattened register dump; register i uses bits [i*XLEN +: XLEN].

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: all registers become 0, busy_vec becomes 0 and busy_cnt becomes 0, immediately on rst assertion, without waiting for a clock edge.
- While rst is high, writes and issues are ignored. Reset mid-operation discards all pending busy state.
- rd_data and rd_busy are combinational from rd_addr and the current state.
- Write: on a clk rising edge with wr_en=1, reg[wr_addr] takes wr_data.
- Register 0 with ZERO_REG=1:
  - a write to address 0 is dropped;
  - rd_data for address 0 is 0;
  - rd_busy for address 0 is 0;
  - iss_en with iss_addr=0 has no effect.
- Scoreboard, updated on each rising edge:
  - iss_en only: busy[iss_addr] is set.
  - wr_en only: busy[wr_addr] is cleared.
  - iss_en and wr_en to the same address: busy stays set, because a new producer is in flight. The data write still occurs.
  - iss_en and wr_en to different addresses: both updates apply.
  - iss_en to an already-busy register: busy stays set and busy_cnt does not change.
  - wr_en to a non-busy register: the data is written and busy_cnt does not change.
- busy_cnt always equals the popcount of busy_vec. It is registered and updated in the same edge as busy_vec, never wraps, and its maximum is NREG (NREG-1 with ZERO_REG=1).
- Port independence: all NRD read ports behave identically and independently. Identical addresses on several ports return identical data.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when wr_en=1 and wr_addr == rd_addr[k] (and is not register 0 with ZERO_REG=1):
  - rd_data[k] returns wr_data in the same cycle;
  - rd_busy[k] reads 0 in that cycle unless iss_en targets the same address in that cycle.
- Undefined: rd_data returns the stored value until the edge after the write, and rd_busy reflects only registered state.

Test Plan:
- Reset: assert rst mid-cycle while register 5 holds 0x1234 and is busy -> rd_data for register 5 = 0 and busy_vec = 0 before the next edge; busy_cnt = 0.
- Write then read: wr_en with register 3 = 0xDEADBEEF, then read register 3 on ports 0 and 1 next cycle -> both return 0xDEADBEEF. A write of 0xFFFFFFFF to register 0 -> register 0 still reads 0.
- Scoreboard: issue registers 7 and 9 on consecutive cycles -> busy_cnt = 2 and rd_busy=1 for register 7. Write register 7 -> busy[7]=0, busy_cnt = 1.
- Simultaneous issue and write to register 4 while register 4 is busy -> busy[4] remains 1, register 4 = new data, busy_cnt unchanged.
- Bypass (REGFILE_BYPASS_EN defined): in the same cycle, wr_en for register 10 = 0xA5A5A5A5 and rd_addr[0]=10 -> rd_data[0]=0xA5A5A5A5 that cycle. Macro undefined -> the old value that cycle, 0xA5A5A5A5 next cycle.
- Saturation: issue every register 1..31 with ZERO_REG=1 -> busy_cnt = 31. Issue register 31 again -> busy_cnt = 31.
